// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the piso/sipo serial link: default width, bit order, FSM states.
package sipo_rx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit counter must hold 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// Serial input, consumer handshake and status outputs of the sipo receiver.
interface sipo_rx_if #(
    parameter int WIDTH = sipo_rx_pkg::DEFAULT_WIDTH
);
    logic             enable;
    logic             serial_in;
    logic             data_ready;
    logic             overrun_clr;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output enable, serial_in, data_ready, overrun_clr,
        input  data_out, data_valid, busy, overrun
    );

    modport slave (
        input  enable, serial_in, data_ready, overrun_clr,
        output data_out, data_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_out_buf.sv
// One-entry output holding register: loads completed words, drains on ready, flags dropped words.
module sipo_out_buf
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             drop;
    logic             accept;

    always_comb begin
        drop    = load_i && valid_q && !ready_i;
        accept  = load_i && !drop;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        // A consume on the same edge as a load frees the slot, so valid stays high.
        if (accept) begin
            data_d  = word_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: counts WIDTH enabled bits, assembles the word and hands it
// to a one-entry output register on the edge that samples the final bit.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic    clk,
    input  logic    reset,
    sipo_rx_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Only WIDTH-1 bits need storing: the final bit goes straight from serial_in into the word.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word;
    logic             shift;
    logic             last;
    logic             complete;
    logic             busy;

    assign shift    = !bus.enable;
    assign last     = (cnt_q == CW'(WIDTH - 1));
    assign complete = shift && last;

    always_comb begin
        if (MSB_FIRST == ORDER_LSB_FIRST) begin
            word = {bus.serial_in, shreg_q};
        end else begin
            word = {shreg_q, bus.serial_in};
        end
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (shift) begin
            shreg_d = (MSB_FIRST == ORDER_LSB_FIRST) ? word[WIDTH-1:1] : word[WIDTH-2:0];
            cnt_d   = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (shift)    state_d = SHIFT;
            SHIFT:   if (complete) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load_i    (complete),
        .word_i    (word),
        .ready_i   (bus.data_ready),
        .clr_i     (bus.overrun_clr),
        .data_o    (bus.data_out),
        .valid_o   (bus.data_valid),
        .overrun_o (bus.overrun)
    );

    assign bus.busy = busy;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: MSB-first and LSB-first instances driven with identical inputs and
// compared against a bit-queue model of the receiver.
module tb_sipo_rx;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(W)) bus_m ();
    sipo_rx_if #(.WIDTH(W)) bus_l ();

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bus_m));
    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bus_l));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit         q[$];
    logic [W-1:0] e_dat_m, e_dat_l;
    logic         e_vld, e_ovr;

    task automatic drive(input logic en, input logic sin, input logic rdy, input logic clr);
        bus_m.enable = en;  bus_l.enable = en;
        bus_m.serial_in = sin;  bus_l.serial_in = sin;
        bus_m.data_ready = rdy;  bus_l.data_ready = rdy;
        bus_m.overrun_clr = clr;  bus_l.overrun_clr = clr;
    endtask

    // One clock: drive on the falling edge, update the model on the rising edge, return 1 ns later.
    task automatic step(input logic rst_v, input logic en, input logic sin,
                        input logic rdy, input logic clr);
        logic [W-1:0] wm, wl;
        logic done, drop;
        @(negedge clk);
        reset = rst_v;
        drive(en, sin, rdy, clr);
        @(posedge clk);
        cyc++;
        if (!rst_v) begin
            q.delete();
            e_dat_m = '0; e_dat_l = '0; e_vld = 1'b0; e_ovr = 1'b0;
        end else begin
            done = 1'b0; wm = '0; wl = '0;
            if (!en) begin
                q.push_back(sin);
                done = (q.size() == W);
            end
            if (done) begin
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = q[i];
                    wl[i]     = q[i];
                end
                q.delete();
            end
            drop = done && e_vld && !rdy;
            if (done && !drop) begin
                e_dat_m = wm; e_dat_l = wl; e_vld = 1'b1;
            end else if (e_vld && rdy) begin
                e_vld = 1'b0;
            end
            if (drop) e_ovr = 1'b1;
            else if (clr) e_ovr = 1'b0;
        end
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic rdy);
        for (int i = 0; i < W; i++) step(1'b1, 1'b0, w[W-1-i], rdy, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus_m.busy, bus_m.data_valid, bus_m.overrun, bus_m.data_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_m got %b/%b/%b/%h exp all zero", bus_m.busy, bus_m.data_valid,
                     bus_m.overrun, bus_m.data_out);
        end
        checks++;
        if ({bus_l.busy, bus_l.data_valid, bus_l.overrun, bus_l.data_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_l got %b/%b/%b/%h exp all zero", bus_l.busy, bus_l.data_valid,
                     bus_l.overrun, bus_l.data_out);
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] w;
        w = 8'b11010101;
        for (int i = 0; i < W; i++) begin
            step(1'b1, 1'b0, w[W-1-i], 1'b1, 1'b0);
            checks++;
            if (bus_m.busy !== (i < W - 1) || bus_m.data_valid !== (i == W - 1)) begin
                errors++;
                $display("FAIL loopback_bit%0d busy/valid got %b/%b exp %b/%b", i, bus_m.busy,
                         bus_m.data_valid, (i < W - 1), (i == W - 1));
            end
        end
        checks++;
        if (bus_m.data_out !== 8'hD5) begin
            errors++;
            $display("FAIL loopback_data got %h exp d5", bus_m.data_out);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus_m.data_valid !== 1'b0 || bus_m.overrun !== 1'b0) begin
            errors++;
            $display("FAIL loopback_pulse valid/ovr got %b/%b exp 0/0", bus_m.data_valid, bus_m.overrun);
        end
    endtask

    task automatic test_pause();
        logic [W-1:0] w;
        w = 8'b10011010;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, w[W-1-i], 1'b1, 1'b0);
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 1'b1, p[0], 1'b1, 1'b0);
            checks++;
            if (bus_m.busy !== 1'b1 || bus_m.data_valid !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold%0d busy/valid got %b/%b exp 1/0", p, bus_m.busy, bus_m.data_valid);
            end
        end
        for (int i = 4; i < W; i++) step(1'b1, 1'b0, w[W-1-i], 1'b1, 1'b0);
        checks++;
        if (bus_m.data_out !== 8'h9A || bus_m.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL pause_data got %h/%b exp 9a/1", bus_m.data_out, bus_m.data_valid);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int hits[$];
        logic [W-1:0] words [2];
        words[0] = 8'hD5;
        words[1] = 8'h9A;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < W; i++) begin
                step(1'b1, 1'b0, words[k][W-1-i], 1'b1, 1'b0);
                if (bus_m.data_valid === 1'b1) hits.push_back(cyc);
                if (i == W - 1) begin
                    checks++;
                    if (bus_m.data_out !== words[k]) begin
                        errors++;
                        $display("FAIL b2b_word%0d got %h exp %h", k, bus_m.data_out, words[k]);
                    end
                end
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        if (bus_m.data_valid === 1'b1) hits.push_back(cyc);
        checks++;
        if (hits.size() != 2 || hits[1] - hits[0] != W || bus_m.overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_spacing got pulses=%0d gap=%0d ovr=%b exp 2/%0d/0", hits.size(),
                     (hits.size() == 2) ? hits[1] - hits[0] : -1, bus_m.overrun, W);
        end
    endtask

    task automatic test_overrun();
        send_word(8'hD5, 1'b0);
        send_word(8'h9A, 1'b0);
        checks++;
        if (bus_m.data_out !== 8'hD5 || bus_m.overrun !== 1'b1 || bus_m.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got %h/%b/%b exp d5/ovr1/vld1", bus_m.data_out,
                     bus_m.overrun, bus_m.data_valid);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus_m.overrun !== 1'b0 || bus_m.data_out !== 8'hD5 || bus_m.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_clr got %b/%h/%b exp 0/d5/1", bus_m.overrun, bus_m.data_out,
                     bus_m.data_valid);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus_m.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drain valid got %b exp 0", bus_m.data_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({bus_m.busy, bus_m.data_valid, bus_m.overrun, bus_m.data_out} !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_zero got %b/%b/%b/%h exp all zero", bus_m.busy, bus_m.data_valid,
                     bus_m.overrun, bus_m.data_out);
        end
        send_word(8'h9A, 1'b1);
        checks++;
        if (bus_m.data_out !== 8'h9A || bus_m.data_valid !== 1'b1 || bus_m.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_word got %h/%b/%b exp 9a/1/0", bus_m.data_out, bus_m.data_valid, bus_m.busy);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] seq;
        seq = 8'b10101011;
        send_word(seq, 1'b1);
        checks++;
        if (bus_l.data_out !== 8'hD5 || bus_l.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL lsb_word got %h/%b exp d5/1", bus_l.data_out, bus_l.data_valid);
        end
        checks++;
        if (bus_m.data_out !== 8'hAB) begin
            errors++;
            $display("FAIL lsb_msb_peer got %h exp ab", bus_m.data_out);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic rst_v, en, sin, rdy, clr, e_busy;
        for (int n = 0; n < 600; n++) begin
            rst_v = ($urandom_range(0, 59) != 0);
            en    = ($urandom_range(0, 9) < 3);
            sin   = 1'($urandom);
            rdy   = ($urandom_range(0, 9) < 4);
            clr   = ($urandom_range(0, 7) == 0);
            step(rst_v, en, sin, rdy, clr);
            e_busy = (q.size() != 0);
            checks++;
            if ({bus_m.busy, bus_m.data_valid, bus_m.overrun, bus_m.data_out}
                    !== {e_busy, e_vld, e_ovr, e_dat_m}) begin
                errors++;
                $display("FAIL rand_m cyc%0d got %b/%b/%b/%h exp %b/%b/%b/%h", cyc, bus_m.busy,
                         bus_m.data_valid, bus_m.overrun, bus_m.data_out, e_busy, e_vld, e_ovr, e_dat_m);
            end
            checks++;
            if ({bus_l.busy, bus_l.data_valid, bus_l.overrun, bus_l.data_out}
                    !== {e_busy, e_vld, e_ovr, e_dat_l}) begin
                errors++;
                $display("FAIL rand_l cyc%0d got %b/%b/%b/%h exp %b/%b/%b/%h", cyc, bus_l.busy,
                         bus_l.data_valid, bus_l.overrun, bus_l.data_out, e_busy, e_vld, e_ovr, e_dat_l);
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_loopback();
        test_pause();
        test_back_to_back();
        test_overrun();
        test_reset_mid_word();
        test_lsb_first();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
